// File: rtl/cordic_sqrt_iter_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg -- shared constants and types for the iterative hyperbolic
// CORDIC square-root unit.
//   DW / IW          : operand/result width and internal datapath width
//   FRAC_W           : fractional bits of every fixed-point value (Q.14)
//   N_STEPS          : micro-rotations per operation
//   SHIFT_TAB        : shift amount used at each step (4 and 13 repeated so
//                      the hyperbolic iteration converges)
//   INV_KH           : 1/K_h in Q2.14, removes the CORDIC gain from x_n
//   A_MIN / A_MAX    : accepted operand range [A_MIN, A_MAX)
//   state_t          : FSM state encoding
// ---------------------------------------------------------------------------
package cordic_pkg;

  localparam int DW      = 16;
  localparam int IW      = 18;
  localparam int FRAC_W  = 14;
  localparam int N_STEPS = 16;
  localparam int STEP_W  = $clog2(N_STEPS);
  localparam int SHIFT_W = 4;

  localparam int INV_KH  = 19784;   // 1/0.828159 in Q2.14
  localparam int A_MIN   = 'h01EC;  // 0.030
  localparam int A_MAX   = 'h8000;  // 2.0

  typedef logic [SHIFT_W-1:0] shift_t;

  localparam shift_t SHIFT_TAB [N_STEPS] = '{
    4'd1, 4'd2,  4'd3,  4'd4,  4'd4,  4'd5,  4'd6,  4'd7,
    4'd8, 4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd13, 4'd14
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic shift_t shift_of(input logic [STEP_W-1:0] step);
    return SHIFT_TAB[step];
  endfunction

endpackage

// File: rtl/cordic_sqrt_iter_addsub.sv
// ---------------------------------------------------------------------------
// addsub -- W-bit ripple-carry adder/subtractor built from full-adder cells.
//   a, b : operands
//   sub  : 0 -> s = a + b ; 1 -> s = a - b (b inverted, carry-in 1)
//   s    : result, wraps modulo 2**W
// ---------------------------------------------------------------------------
module addsub #(
  parameter int W = cordic_pkg::IW
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] s
);

  logic [W-1:0] b_eff;

  assign b_eff = b ^ {W{sub}};

  // Each cell owns its carry-in as a scalar; the carry into cell i is the
  // carry-out of cell i-1, formed here from that cell's inputs.
  for (genvar i = 0; i < W; i++) begin : g_fa
    logic cin;

    if (i == 0) begin : g_lsb
      assign cin = sub;
    end else begin : g_chain
      assign cin = (a[i-1] & b_eff[i-1]) |
                   (g_fa[i-1].cin & (a[i-1] ^ b_eff[i-1]));
    end

    assign s[i] = a[i] ^ b_eff[i] ^ cin;
  end

endmodule

// File: rtl/cordic_sqrt_iter.sv
// ---------------------------------------------------------------------------
// cordic_sqrt_iter -- iterative square root by hyperbolic CORDIC vectoring.
// One micro-rotation per clock; 18 edges from the accepting edge to done.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   start     : begin a computation (sampled in IDLE only)
//   a_in      : unsigned Q2.14 operand, captured on the accepting edge
//   busy      : high while iterating / scaling
//   done      : one-cycle pulse, result and range_err valid
//   result    : unsigned Q2.14 sqrt(a_in), held until the next result
//   range_err : operand outside [0x01EC, 0x8000); result forced to 0
// ---------------------------------------------------------------------------
module cordic_sqrt_iter #(
  parameter int DW = cordic_pkg::DW,
  parameter int IW = cordic_pkg::IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a_in,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          range_err
);

  import cordic_pkg::*;

  // Product width: signed IW-bit x times a positive 16-bit constant.
  localparam int PW = IW + 18;
  localparam logic signed [IW-1:0] QUARTER = IW'(1 << (FRAC_W - 2));

  state_t state, state_nxt;

  logic signed [IW-1:0] x, y;
  logic signed [IW-1:0] x_nxt, y_nxt;
  logic signed [IW-1:0] x_sh, y_sh;
  logic signed [IW-1:0] a_ext;
  logic [STEP_W-1:0]    step;
  logic                 range_bad;
  logic                 a_bad;
  logic                 y_pos;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] scaled;
  logic [DW-1:0]        res_sat;

  // ---------------- operand conditioning and range check ----------------
  assign a_ext = $signed(IW'(a_in));
  assign a_bad = (a_in < DW'(A_MIN)) || (a_in >= DW'(A_MAX));

  // ---------------- one micro-rotation ----------------
  // Rotate toward y = 0: subtract when y is non-negative, add otherwise.
  assign y_pos = ~y[IW-1];
  assign x_sh  = x >>> shift_of(step);
  assign y_sh  = y >>> shift_of(step);

  addsub #(.W(IW)) u_x_addsub (
    .a   (x),
    .b   (y_sh),
    .sub (y_pos),
    .s   (x_nxt)
  );

  addsub #(.W(IW)) u_y_addsub (
    .a   (y),
    .b   (x_sh),
    .sub (y_pos),
    .s   (y_nxt)
  );

  // ---------------- gain removal and saturation ----------------
  assign prod   = PW'(x) * PW'(INV_KH);
  assign scaled = prod >>> FRAC_W;

  always_comb begin
    res_sat = scaled[DW-1:0];
    if (scaled[PW-1]) begin
      res_sat = '0;
    end else if (|scaled[PW-2:DW]) begin
      res_sat = '1;
    end
  end

  // ---------------- FSM state register ----------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM next state and outputs ----------------
  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (step == STEP_W'(N_STEPS - 1)) state_nxt = SCALE;
      end
      SCALE: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      step      <= '0;
      range_bad <= 1'b0;
      result    <= '0;
      range_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            // x0 - y0 = 0.5 and x0 + y0 = 2a, so x0^2 - y0^2 = a.
            x         <= a_ext + QUARTER;
            y         <= a_ext - QUARTER;
            step      <= '0;
            range_bad <= a_bad;
          end
        end
        ITER: begin
          x    <= x_nxt;
          y    <= y_nxt;
          step <= step + 1'b1;
        end
        SCALE: begin
          result    <= range_bad ? '0 : res_sat;
          range_err <= range_bad;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sqrt_iter.sv
// ---------------------------------------------------------------------------
// tb_cordic_sqrt_iter -- directed self-checking bench for cordic_sqrt_iter.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_cordic_sqrt_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        range_err;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  cordic_sqrt_iter dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_in      (a_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .range_err (range_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [15:0] obs,
                            input logic [15:0] ideal);
    int d;
    d = int'(obs) - int'(ideal);
    total++;
    assert (d >= -4 && d <= 4) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h +/-4", tag, obs, ideal);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation from IDLE, wait (bounded) for done, check latency,
  // busy and the one-cycle done pulse; leaves the DUT back in IDLE.
  task automatic run_op(input string name, input logic [15:0] a,
                        output logic [15:0] res, output logic err);
    int lat;
    a_in  = a;
    start = 1'b1;
    step_clk();
    start = 1'b0;
    lat   = 1;
    check({name, " busy after accept"}, 32'(busy), 32'd1);
    while (!done && lat < 40) begin
      step_clk();
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'd18);
    check({name, " busy low at done"}, 32'(busy), 32'd0);
    res = result;
    err = range_err;
    step_clk();
    check({name, " done pulse width"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [15:0] r;
    logic        e;
    int          lat;
    int          nd;
    int          c1;
    int          c2;
    logic [15:0] r1;

    rst   = 1'b0;
    start = 1'b0;
    a_in  = '0;
    #1 rst = 1'b1;
    #1;
    check("reset busy",      32'(busy),      32'd0);
    check("reset done",      32'(done),      32'd0);
    check("reset result",    32'(result),    32'd0);
    check("reset range_err", 32'(range_err), 32'd0);

    // start is ignored while reset is held
    a_in  = 16'h4000;
    start = 1'b1;
    repeat (3) step_clk();
    check("start during rst busy", 32'(busy), 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    step_clk();
    check("idle after rst release", 32'(busy), 32'd0);

    // main function
    run_op("sqrt 1.0", 16'h4000, r, e);
    check_near("sqrt 1.0 result", r, 16'h4000);
    check("sqrt 1.0 range_err", 32'(e), 32'd0);

    run_op("sqrt 0.25", 16'h1000, r, e);
    check_near("sqrt 0.25 result", r, 16'h2000);
    check("sqrt 0.25 range_err", 32'(e), 32'd0);

    run_op("sqrt 1.96", 16'h7D71, r, e);
    check_near("sqrt 1.96 result", r, 16'h599A);
    check("sqrt 1.96 range_err", 32'(e), 32'd0);

    // range boundaries
    run_op("low 0x0100", 16'h0100, r, e);
    check("low 0x0100 range_err", 32'(e), 32'd1);
    check("low 0x0100 result",    32'(r), 32'd0);

    run_op("high 0x8000", 16'h8000, r, e);
    check("high 0x8000 range_err", 32'(e), 32'd1);
    check("high 0x8000 result",    32'(r), 32'd0);

    run_op("edge 0x01EB", 16'h01EB, r, e);
    check("edge 0x01EB range_err", 32'(e), 32'd1);

    run_op("edge 0x01EC", 16'h01EC, r, e);
    check("edge 0x01EC range_err", 32'(e), 32'd0);

    run_op("edge 0x7FFF", 16'h7FFF, r, e);
    check("edge 0x7FFF range_err", 32'(e), 32'd0);

    // start pulsed with another operand during ITER is ignored
    a_in  = 16'h1000;
    start = 1'b1;
    step_clk();
    start = 1'b0;
    lat   = 1;
    repeat (4) begin
      step_clk();
      lat++;
    end
    a_in  = 16'h4000;
    start = 1'b1;
    step_clk();
    lat++;
    start = 1'b0;
    a_in  = '0;
    while (!done && lat < 40) begin
      step_clk();
      lat++;
    end
    check("mid-start latency", 32'(lat), 32'd18);
    check_near("mid-start result", result, 16'h2000);
    nd = 0;
    repeat (30) begin
      step_clk();
      if (done) nd++;
    end
    check("mid-start single done", 32'(nd), 32'd0);

    // reset at step 7 of ITER, outputs clear with no clock edge
    a_in  = 16'h4000;
    start = 1'b1;
    step_clk();
    start = 1'b0;
    check("pre-reset busy", 32'(busy), 32'd1);
    repeat (7) step_clk();
    #2 rst = 1'b1;
    #1;
    check("async rst busy",      32'(busy),      32'd0);
    check("async rst done",      32'(done),      32'd0);
    check("async rst result",    32'(result),    32'd0);
    check("async rst range_err", 32'(range_err), 32'd0);
    start = 1'b1;
    repeat (2) step_clk();
    start = 1'b0;
    rst   = 1'b0;
    nd = 0;
    repeat (30) begin
      step_clk();
      if (done) nd++;
    end
    check("no done after abort", 32'(nd), 32'd0);
    check("idle after abort", 32'(busy), 32'd0);

    run_op("post-reset", 16'h4000, r, e);
    check_near("post-reset result", r, 16'h4000);
    check("post-reset range_err", 32'(e), 32'd0);

    // start held high: second acceptance right after DONE
    a_in  = 16'h1000;
    start = 1'b1;
    nd = 0;
    c1 = 0;
    c2 = 0;
    r1 = '0;
    for (int k = 0; k < 80 && nd < 2; k++) begin
      step_clk();
      if (done) begin
        nd++;
        if (nd == 1) begin
          c1 = cyc;
          r1 = result;
        end else begin
          c2 = cyc;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b done count", 32'(nd), 32'd2);
    check("b2b done spacing", 32'(c2 - c1), 32'd19);
    check_near("b2b first result", r1, 16'h2000);
    check_near("b2b second result", result, 16'h2000);
    repeat (3) step_clk();
    check("b2b returns idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
